vis_correlator: RTL and testbench
=================================

Name: vis_correlator

Overview:
- Consumes the time-multiplexed, bank-ordered antenna IQ stream from the signal input buffer, in the correlator (vis_clk) domain.
- Computes 1-bit complex cross-correlations for PAIRS antenna pairs in parallel. The pair set is selected by the timeslice index.
- Sums each pair over COUNT consecutive samples.
- Emits one set of partial visibility sums per timeslice to the final-stage accumulators.

Parameters:
- WIDTH, 32, number of antennas (bits per idata/qdata word).
- TRATE, 30, timeslices per block; TBITS = $clog2(TRATE).
- COUNT, 15, samples summed per timeslice per pair; CBITS = $clog2(COUNT).
- PAIRS, 8, parallel correlator units (1..WIDTH-1).
- SBITS, $clog2(2*COUNT+1) (local), width of one partial sum.

Ports:
- vis_clk  input  1  correlator clock.
- reset_n  input  1  asynchronous active-low reset.
- valid_i  input  1  input sample valid.
- first_i  input  1  first sample of a block (qualified by valid_i).
- last_i  input  1  final sample of a block (qualified by valid_i).
- taddr_i  input  TBITS  timeslice index of current sample.
- idata_i  input  WIDTH  in-phase sign bits, one per antenna.
- qdata_i  input  WIDTH  quadrature sign bits, one per antenna.
- valid_o  output  1  one-cycle strobe, partial sums valid.
- last_o  output  1  emitted group ended with last_i.
- taddr_o  output  TBITS  timeslice of emitted sums.
- re_o  output  PAIRS*SBITS  real-part counts; unit u at [u*SBITS +: SBITS].
- im_o  output  PAIRS*SBITS  imaginary-part counts, same packing.
- err_o  output  1  sticky framing error.

Behaviour:
- Reset: asynchronous, active-low. Clock is vis_clk, reset is reset_n. All outputs, accumulators, sample counter and pipeline valids go to 0. Deassertion is synchronous to vis_clk at the integration level.
- Sign encoding: bit 1 = +1, bit 0 = -1.
- Pair mapping: unit u at timeslice t correlates antennas a = u and b = (u + t + 1) mod WIDTH.
- Per-sample increments per unit:
  - re_inc = xnor(ia,ib) + xnor(qa,qb).
  - im_inc = xnor(qa,ib) + xor(ia,qb).
  - Each is in 0..2.
  - True visibility = 2*count - 2*COUNT.
- Pipeline stage 1: registers valid, first, last, taddr and all increments of each accepted sample.
- Pipeline stage 2: accumulators plus sample counter cnt (CBITS).
- valid_i low: sample ignored; counters and accumulators hold. Gaps of any length are legal.
- Group start: sample with cnt == 0 or first_i = 1.
  - Accumulators load the increments (not add).
  - taddr is latched.
  - first_i mid-group discards the partial sums silently and restarts at cnt = 0.
- Group completion: when the COUNT-th sample of a group is accumulated, cnt wraps to 0. On the following edge:
  - re_o/im_o load the final sums, taddr_o loads the latched taddr.
  - last_o loads the last flag of that sample.
  - valid_o pulses high for exactly one cycle.
  - Latency: valid_o is high in the cycle starting 2 edges after the edge that sampled the group's final valid_i.
- re_o, im_o, taddr_o and last_o hold until the next completion.
- err_o is set and stays set until reset on any of:
  - last_i with a sample that is not the COUNT-th of its group;
  - taddr_i differing from the latched taddr within a group.
  - Data flow is unaffected by err_o.
- Back-to-back groups with no gap: completion of group n and start of group n+1 on consecutive samples must both work, with no lost sample.
- Arithmetic: accumulators are SBITS wide and cannot overflow (max 2*COUNT).
- No backpressure: the downstream consumer must accept every valid_o.

Test Plan:
- Reset, then 15 valid samples at taddr 0, idata = qdata = all ones, first_i on sample 0 -> one valid_o, 2 cycles after the 15th sample, with taddr_o = 0, every re field = 30, every im field = 15, last_o = 0.
- As above but idata bit 1 = 0 -> unit0 (pair 0,1) re = 15, im = 0; unit1 (pair 1,2) re = 15, im = 30; units 2..7 re = 30, im = 15.
- Full block of 30 timeslices x 15 samples with random gaps in valid_i -> exactly 30 valid_o strobes, taddr_o = 0..29 in order, last_o = 1 only on the 30th, sums match software model.
- first_i asserted on the 7th sample of a group -> first 6 samples discarded; next valid_o after 15 more samples; err_o = 0.
- last_i on the 10th sample of a group -> err_o = 1 and remains 1; a group in progress still completes normally.
- reset_n pulsed low asynchronously mid-group -> all outputs 0 immediately; the next 15-sample group produces correct sums with no residue.

Source files
------------

// File: rtl/vis_correlator_if.sv
// vis_correlator_if
//   Groups the sample stream and the partial-sum result bus of the
//   1-bit visibility correlator into one bundle.
//
//   Sample stream (master -> slave):
//     valid_i  sample valid
//     first_i  first sample of a block
//     last_i   final sample of a block
//     taddr_i  timeslice index of the current sample
//     idata_i  in-phase sign bits, one per antenna
//     qdata_i  quadrature sign bits, one per antenna
//   Result bus (slave -> master):
//     valid_o  one-cycle strobe, partial sums valid
//     last_o   emitted group ended with last_i
//     taddr_o  timeslice of the emitted sums
//     re_o     real-part counts, unit u at [u*SBITS +: SBITS]
//     im_o     imaginary-part counts, same packing
//     err_o    sticky framing error
interface vis_correlator_if #(
  parameter int WIDTH = 32,
  parameter int TRATE = 30,
  parameter int COUNT = 15,
  parameter int PAIRS = 8
);
  localparam int TBITS = (TRATE > 1) ? $clog2(TRATE) : 1;
  localparam int SBITS = $clog2(2 * COUNT + 1);

  logic                   valid_i;
  logic                   first_i;
  logic                   last_i;
  logic [TBITS-1:0]       taddr_i;
  logic [WIDTH-1:0]       idata_i;
  logic [WIDTH-1:0]       qdata_i;

  logic                   valid_o;
  logic                   last_o;
  logic [TBITS-1:0]       taddr_o;
  logic [PAIRS*SBITS-1:0] re_o;
  logic [PAIRS*SBITS-1:0] im_o;
  logic                   err_o;

  modport master (
    output valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
    input  valid_o, last_o, taddr_o, re_o, im_o, err_o
  );

  modport slave (
    input  valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
    output valid_o, last_o, taddr_o, re_o, im_o, err_o
  );
endinterface

// File: rtl/vis_correlator.sv
// vis_correlator
//   1-bit complex cross-correlator.  Each of PAIRS units correlates
//   antenna a = u with antenna b = (u + t + 1) mod WIDTH, where t is the
//   timeslice of the sample, and counts the per-sample increments over
//   COUNT consecutive valid samples.  One set of partial sums is emitted
//   per completed group.
//
//   Ports:
//     vis_clk  correlator clock
//     reset_n  asynchronous active-low reset
//     vis      vis_correlator_if.slave (sample stream in, sums out)
//
//   Pipeline:
//     stage 1  register the accepted sample and its per-unit increments
//     stage 2  accumulate, count samples, flag group completion
//     output   load sums / taddr / last and pulse valid_o
module vis_correlator #(
  parameter int WIDTH = 32,
  parameter int TRATE = 30,
  parameter int COUNT = 15,
  parameter int PAIRS = 8
) (
  input  logic             vis_clk,
  input  logic             reset_n,
  vis_correlator_if.slave  vis
);

  localparam int TBITS = (TRATE > 1) ? $clog2(TRATE) : 1;
  localparam int CBITS = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int SBITS = $clog2(2 * COUNT + 1);
  localparam int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CBITS-1:0] LAST_POS = CBITS'(COUNT - 1);

  // Partner antenna of unit u at timeslice t, wrapping round the array.
  function automatic logic [AW-1:0] b_index(input int u, input logic [TBITS-1:0] t);
    int s;
    s = (u + int'(t) + 1) % WIDTH;
    return AW'(s);
  endfunction

  logic [1:0]       re_inc [PAIRS];
  logic [1:0]       im_inc [PAIRS];

  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic [TBITS-1:0] s1_taddr;
  logic [1:0]       s1_re_inc [PAIRS];
  logic [1:0]       s1_im_inc [PAIRS];

  logic [SBITS-1:0] acc_re [PAIRS];
  logic [SBITS-1:0] acc_im [PAIRS];
  logic [CBITS-1:0] cnt;
  logic [TBITS-1:0] grp_taddr;
  logic             done;
  logic             done_last;

  logic             start;
  logic [CBITS-1:0] pos;
  logic             at_end;

  logic [PAIRS*SBITS-1:0] re_pack;
  logic [PAIRS*SBITS-1:0] im_pack;

  logic                   valid_q;
  logic                   last_q;
  logic [TBITS-1:0]       taddr_q;
  logic [PAIRS*SBITS-1:0] re_q;
  logic [PAIRS*SBITS-1:0] im_q;
  logic                   err_q;

  // Sign bits encode +1 as 1 and -1 as 0, so a product of two signs is
  // +1 exactly when the bits agree (xnor).  The real part sums ia*ib and
  // qa*qb; the imaginary part sums qa*ib and -(ia*qb), the latter being
  // +1 when the bits differ (xor).  Each increment is therefore 0..2.
  always_comb begin
    logic ia, qa, ib, qb;
    logic [AW-1:0] b;
    ia = 1'b0;
    qa = 1'b0;
    ib = 1'b0;
    qb = 1'b0;
    b  = '0;
    for (int u = 0; u < PAIRS; u++) begin
      b  = b_index(u, vis.taddr_i);
      ia = vis.idata_i[AW'(u)];
      qa = vis.qdata_i[AW'(u)];
      ib = vis.idata_i[b];
      qb = vis.qdata_i[b];
      re_inc[u] = {1'b0, ia ~^ ib} + {1'b0, qa ~^ qb};
      im_inc[u] = {1'b0, qa ~^ ib} + {1'b0, ia ^ qb};
    end
  end

  // Stage 1: capture every accepted sample.  The data fields only move on
  // valid_i so idle gaps leave the last sample in place harmlessly.
  always_ff @(posedge vis_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_taddr <= '0;
      for (int u = 0; u < PAIRS; u++) begin
        s1_re_inc[u] <= '0;
        s1_im_inc[u] <= '0;
      end
    end else begin
      s1_valid <= vis.valid_i;
      if (vis.valid_i) begin
        s1_first <= vis.first_i;
        s1_last  <= vis.last_i;
        s1_taddr <= vis.taddr_i;
        for (int u = 0; u < PAIRS; u++) begin
          s1_re_inc[u] <= re_inc[u];
          s1_im_inc[u] <= im_inc[u];
        end
      end
    end
  end

  // A group starts either naturally (counter at zero) or when first_i
  // forces a restart, which throws away any partial sums.  pos is the
  // position of the stage-1 sample within its group.
  always_comb begin
    start  = (cnt == '0) || s1_first;
    pos    = start ? '0 : cnt;
    at_end = (pos == LAST_POS);
  end

  // Stage 2: accumulators, sample counter and the sticky framing error.
  // The first sample of a group loads rather than adds, so no clearing
  // cycle is needed between back-to-back groups.
  always_ff @(posedge vis_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      grp_taddr <= '0;
      done      <= 1'b0;
      done_last <= 1'b0;
      err_q     <= 1'b0;
      for (int u = 0; u < PAIRS; u++) begin
        acc_re[u] <= '0;
        acc_im[u] <= '0;
      end
    end else begin
      done <= s1_valid && at_end;
      if (s1_valid) begin
        cnt <= at_end ? '0 : pos + CBITS'(1);
        if (at_end) begin
          done_last <= s1_last;
        end
        if (start) begin
          grp_taddr <= s1_taddr;
          for (int u = 0; u < PAIRS; u++) begin
            acc_re[u] <= SBITS'(s1_re_inc[u]);
            acc_im[u] <= SBITS'(s1_im_inc[u]);
          end
        end else begin
          for (int u = 0; u < PAIRS; u++) begin
            acc_re[u] <= acc_re[u] + SBITS'(s1_re_inc[u]);
            acc_im[u] <= acc_im[u] + SBITS'(s1_im_inc[u]);
          end
        end
        if ((s1_last && !at_end) || (!start && (s1_taddr != grp_taddr))) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Flatten the accumulator arrays into the packed result layout.
  always_comb begin
    re_pack = '0;
    im_pack = '0;
    for (int u = 0; u < PAIRS; u++) begin
      re_pack[u*SBITS +: SBITS] = acc_re[u];
      im_pack[u*SBITS +: SBITS] = acc_im[u];
    end
  end

  // Output stage: results are loaded the edge after completion and held
  // until the next group completes; valid_o is a single-cycle strobe.
  always_ff @(posedge vis_clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      taddr_q <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      valid_q <= done;
      if (done) begin
        last_q  <= done_last;
        taddr_q <= grp_taddr;
        re_q    <= re_pack;
        im_q    <= im_pack;
      end
    end
  end

  assign vis.valid_o = valid_q;
  assign vis.last_o  = last_q;
  assign vis.taddr_o = taddr_q;
  assign vis.re_o    = re_q;
  assign vis.im_o    = im_q;
  assign vis.err_o   = err_q;

endmodule

// File: tb/tb_vis_correlator.sv
// tb_vis_correlator
//   Scoreboard bench for vis_correlator.  Stimulus pushes the expected
//   result of each group into a queue; a monitor on the falling edge pops
//   and compares whenever valid_o is seen.  Directed groups use hand
//   values; random-data groups use a complex-product reference model.
module tb_vis_correlator;

  localparam int WIDTH = 32;
  localparam int TRATE = 30;
  localparam int COUNT = 15;
  localparam int PAIRS = 8;
  localparam int TBITS = $clog2(TRATE);
  localparam int SBITS = $clog2(2 * COUNT + 1);

  typedef struct packed {
    logic [TBITS-1:0]       taddr;
    logic                   last;
    logic [PAIRS*SBITS-1:0] re;
    logic [PAIRS*SBITS-1:0] im;
    logic [31:0]            due;
  } exp_t;

  logic vis_clk = 1'b0;
  logic reset_n;

  vis_correlator_if #(.WIDTH(WIDTH), .TRATE(TRATE), .COUNT(COUNT), .PAIRS(PAIRS)) vif ();

  vis_correlator #(.WIDTH(WIDTH), .TRATE(TRATE), .COUNT(COUNT), .PAIRS(PAIRS)) dut (
    .vis_clk (vis_clk),
    .reset_n (reset_n),
    .vis     (vif)
  );

  always #5 vis_clk = ~vis_clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_edge = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   m_re [PAIRS];
  int   m_im [PAIRS];

  always @(posedge vis_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation,
  // including the cycle in which it was due.
  always @(negedge vis_clk) begin
    if (reset_n === 1'b1 && vif.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("spurious_valid_o", 64'(vif.valid_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("taddr_o", 64'(vif.taddr_o), 64'(mon_e.taddr));
        check_output("last_o",  64'(vif.last_o),  64'(mon_e.last));
        check_output("re_o",    64'(vif.re_o),    64'(mon_e.re));
        check_output("im_o",    64'(vif.im_o),    64'(mon_e.im));
        check_output("latency", 64'(cyc),         64'(mon_e.due));
      end
    end
  end

  task automatic model_clear();
    for (int u = 0; u < PAIRS; u++) begin
      m_re[u] = 0;
      m_im[u] = 0;
    end
  endtask

  // Reference: accumulate a * conj(b) with +/-1 components.
  task automatic model_add(input int t, input logic [WIDTH-1:0] id, input logic [WIDTH-1:0] qd);
    int b, ia, qa, ib, qb;
    for (int u = 0; u < PAIRS; u++) begin
      b  = (u + t + 1) % WIDTH;
      ia = id[u] ? 1 : -1;
      qa = qd[u] ? 1 : -1;
      ib = id[b] ? 1 : -1;
      qb = qd[b] ? 1 : -1;
      m_re[u] += ia * ib + qa * qb;
      m_im[u] += qa * ib - ia * qb;
    end
  endtask

  task automatic push_model(input int t, input bit last);
    exp_t e;
    e.taddr = TBITS'(t);
    e.last  = last;
    e.re    = '0;
    e.im    = '0;
    for (int u = 0; u < PAIRS; u++) begin
      e.re[u*SBITS +: SBITS] = SBITS'((m_re[u] + 2 * COUNT) / 2);
      e.im[u*SBITS +: SBITS] = SBITS'((m_im[u] + 2 * COUNT) / 2);
    end
    e.due = 32'(last_edge + 2);
    sb.push_back(e);
  endtask

  task automatic push_hand(input int t, input bit last,
                           input logic [PAIRS*SBITS-1:0] re, input logic [PAIRS*SBITS-1:0] im);
    exp_t e;
    e.taddr = TBITS'(t);
    e.last  = last;
    e.re    = re;
    e.im    = im;
    e.due   = 32'(last_edge + 2);
    sb.push_back(e);
  endtask

  // Drive one valid sample after an optional idle gap; returns just after
  // the edge that sampled it, with that edge's cycle number in last_edge.
  task automatic apply_stimulus(input bit f, input bit l, input logic [TBITS-1:0] t,
                                input logic [WIDTH-1:0] id, input logic [WIDTH-1:0] qd,
                                input int gap);
    vif.valid_i = 1'b0;
    repeat (gap) begin
      @(posedge vis_clk);
      #1;
    end
    vif.valid_i = 1'b1;
    vif.first_i = f;
    vif.last_i  = l;
    vif.taddr_i = t;
    vif.idata_i = id;
    vif.qdata_i = qd;
    @(posedge vis_clk);
    #1;
    last_edge   = cyc;
    vif.valid_i = 1'b0;
    vif.first_i = 1'b0;
    vif.last_i  = 1'b0;
  endtask

  // One COUNT-sample group; the model tracks it, the caller pushes.
  task automatic send_group(input int t, input bit first0, input int last_idx,
                            input int gap_max, input bit rnd,
                            input logic [WIDTH-1:0] id_fix, input logic [WIDTH-1:0] qd_fix);
    logic [WIDTH-1:0] id, qd;
    int gap;
    model_clear();
    for (int s = 0; s < COUNT; s++) begin
      id  = rnd ? WIDTH'($urandom) : id_fix;
      qd  = rnd ? WIDTH'($urandom) : qd_fix;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      apply_stimulus(first0 && (s == 0), s == last_idx, TBITS'(t), id, qd, gap);
      model_add(t, id, qd);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge vis_clk);
      #1;
    end
    repeat (4) begin
      @(posedge vis_clk);
      #1;
    end
    check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_valid_o"}, 64'(vif.valid_o), 64'd0);
    check_output({tag, "_last_o"},  64'(vif.last_o),  64'd0);
    check_output({tag, "_taddr_o"}, 64'(vif.taddr_o), 64'd0);
    check_output({tag, "_re_o"},    64'(vif.re_o),    64'd0);
    check_output({tag, "_im_o"},    64'(vif.im_o),    64'd0);
    check_output({tag, "_err_o"},   64'(vif.err_o),   64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PAIRS*SBITS-1:0] re_v, im_v;
    logic [WIDTH-1:0] id, qd;

    reset_n     = 1'b0;
    vif.valid_i = 1'b0;
    vif.first_i = 1'b0;
    vif.last_i  = 1'b0;
    vif.taddr_i = '0;
    vif.idata_i = '0;
    vif.qdata_i = '0;
    repeat (3) @(posedge vis_clk);
    #1;
    check_idle_outputs("reset");
    @(negedge vis_clk);
    reset_n = 1'b1;
    @(posedge vis_clk);
    #1;

    $display("[TB] all-ones group");
    send_group(0, 1'b1, -1, 0, 1'b0, '1, '1);
    push_hand(0, 1'b0, {PAIRS{SBITS'(30)}}, {PAIRS{SBITS'(15)}});
    drain();

    $display("[TB] idata bit 1 cleared");
    send_group(0, 1'b1, -1, 0, 1'b0, ~WIDTH'(2), '1);
    re_v = {PAIRS{SBITS'(30)}};
    im_v = {PAIRS{SBITS'(15)}};
    re_v[0 +: SBITS]     = SBITS'(15);
    im_v[0 +: SBITS]     = SBITS'(0);
    re_v[SBITS +: SBITS] = SBITS'(15);
    im_v[SBITS +: SBITS] = SBITS'(30);
    push_hand(0, 1'b0, re_v, im_v);
    drain();

    $display("[TB] full block with gaps");
    for (int t = 0; t < TRATE; t++) begin
      send_group(t, t == 0, (t == TRATE - 1) ? COUNT - 1 : -1, 2, 1'b1, '0, '0);
      push_model(t, t == TRATE - 1);
    end
    drain();
    check_output("block_err_o", 64'(vif.err_o), 64'd0);

    $display("[TB] first_i mid-group restart");
    for (int s = 0; s < 6; s++) begin
      apply_stimulus(s == 0, 1'b0, TBITS'(5), WIDTH'($urandom), WIDTH'($urandom), 0);
    end
    send_group(5, 1'b1, -1, 1, 1'b1, '0, '0);
    push_model(5, 1'b0);
    drain();
    check_output("restart_err_o", 64'(vif.err_o), 64'd0);

    $display("[TB] early last_i");
    send_group(3, 1'b0, 9, 0, 1'b1, '0, '0);
    push_model(3, 1'b0);
    drain();
    check_output("early_last_err_o", 64'(vif.err_o), 64'd1);
    send_group(8, 1'b0, -1, 1, 1'b1, '0, '0);
    push_model(8, 1'b0);
    drain();
    check_output("sticky_err_o", 64'(vif.err_o), 64'd1);

    $display("[TB] asynchronous reset mid-group");
    for (int s = 0; s < 7; s++) begin
      apply_stimulus(1'b0, 1'b0, TBITS'(2), WIDTH'($urandom), WIDTH'($urandom), 0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge vis_clk);
    reset_n = 1'b1;
    @(posedge vis_clk);
    #1;
    send_group(4, 1'b0, -1, 0, 1'b1, '0, '0);
    push_model(4, 1'b0);
    drain();
    check_output("post_reset_err_o", 64'(vif.err_o), 64'd0);

    $display("[TB] taddr change within group");
    model_clear();
    for (int s = 0; s < COUNT; s++) begin
      id = WIDTH'($urandom);
      qd = WIDTH'($urandom);
      apply_stimulus(1'b0, 1'b0, TBITS'((s == 4) ? 7 : 6), id, qd, 0);
      model_add((s == 4) ? 7 : 6, id, qd);
    end
    push_model(6, 1'b0);
    drain();
    check_output("taddr_err_o", 64'(vif.err_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
